kul_mult_pipe: RTL and testbench

- Parametrised, pipelined Kulkarni-style approximate recursive multiplier. Operand width is WIDTH, a power of two.
- Built from 2x2 base blocks; combine levels are registered and driven by a valid/ready handshake.
- Exact vs approximate mode is selected per transaction. A tag travels alongside each transaction.
- Next generation of the team's fixed-width combinational Kul2/Kul4/Kul8 chain; used by datapath accelerators that need throughput of one product per cycle.

---
 rtl/kul_mult_pkg.sv | 19 +
 rtl/kul_base2.sv | 18 +
 rtl/kul_mult_pipe.sv | 130 +++++++++++++
 tb/tb_kul_mult_pipe.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kul_mult_pkg.sv
// Shared constants and helpers for the pipelined Kulkarni approximate multiplier.
package kul_mult_pkg;

    localparam int unsigned KUL_BASE_W     = 2;
    localparam logic [3:0]  KUL_APPROX_3X3 = 4'd7;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/kul_base2.sv
// 2x2 multiplier base block; in approximate mode 3x3 yields 7 instead of 9.
module kul_base2
    import kul_mult_pkg::*;
(
    input  logic [KUL_BASE_W-1:0] a_i,
    input  logic [KUL_BASE_W-1:0] b_i,
    input  logic                  approx_i,
    output logic [3:0]            p_o,
    output logic                  hit_o
);

    logic [3:0] exact;

    assign exact = {2'b00, a_i} * {2'b00, b_i};
    assign hit_o = approx_i & (a_i == 2'd3) & (b_i == 2'd3);
    assign p_o   = hit_o ? KUL_APPROX_3X3 : exact;

endmodule

// File: rtl/kul_mult_pipe.sv
// Pipelined recursive Kulkarni multiplier: base products in stage 1, one combine level per stage.
// Optional out_err flag enabled by defining KUL_MULT_ERR_FLAG_EN.
module kul_mult_pipe
    import kul_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_approx,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_y,
`ifdef KUL_MULT_ERR_FLAG_EN
    output logic                 out_err,
`endif
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned L  = clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    logic stall;

    genvar s, i, j;
    for (s = 1; s <= L; s++) begin : g_stage
        // N sub-operands per operand at this level; products indexed [a_digit*N + b_digit]
        localparam int unsigned N = WIDTH >> s;

        logic [PW-1:0]    prod_d [N*N];
        logic [PW-1:0]    prod_q [N*N];
        logic             valid_d;
        logic             valid_q;
        logic [TAG_W-1:0] tag_d;
        logic [TAG_W-1:0] tag_q;
`ifdef KUL_MULT_ERR_FLAG_EN
        logic             err_d;
        logic             err_q;
`endif

        if (s == 1) begin : g_base
            logic [N*N-1:0] hit;

            for (i = 0; i < N; i++) begin : g_row
                for (j = 0; j < N; j++) begin : g_col
                    logic [3:0] p;

                    kul_base2 u_base (
                        .a_i      (in_a[i*KUL_BASE_W +: KUL_BASE_W]),
                        .b_i      (in_b[j*KUL_BASE_W +: KUL_BASE_W]),
                        .approx_i (in_approx),
                        .p_o      (p),
                        .hit_o    (hit[i*N+j])
                    );

                    assign prod_d[i*N+j] = PW'(p);
                end
            end

            assign valid_d = in_valid;
            assign tag_d   = in_tag;
`ifdef KUL_MULT_ERR_FLAG_EN
            assign err_d   = |hit;
`else
            logic unused_hit;
            assign unused_hit = ^hit;
`endif
        end else begin : g_comb
            localparam int unsigned NP = 2 * N;
            localparam int unsigned K  = 1 << (s - 1);

            for (i = 0; i < N; i++) begin : g_row
                for (j = 0; j < N; j++) begin : g_col
                    logic [PW-1:0] ll, hl, lh, hh;

                    assign ll = g_stage[s-1].prod_q[(2*i)*NP + 2*j];
                    assign hl = g_stage[s-1].prod_q[(2*i+1)*NP + 2*j];
                    assign lh = g_stage[s-1].prod_q[(2*i)*NP + 2*j+1];
                    assign hh = g_stage[s-1].prod_q[(2*i+1)*NP + 2*j+1];

                    assign prod_d[i*N+j] = ll + ((hl + lh) << K) + (hh << (2*K));
                end
            end

            assign valid_d = g_stage[s-1].valid_q;
            assign tag_d   = g_stage[s-1].tag_q;
`ifdef KUL_MULT_ERR_FLAG_EN
            assign err_d   = g_stage[s-1].err_q;
`endif
        end

        // Data registers only load on a valid slot so bubbles leave the last result in place
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                tag_q   <= '0;
                prod_q  <= '{default: '0};
`ifdef KUL_MULT_ERR_FLAG_EN
                err_q   <= 1'b0;
`endif
            end else if (!stall) begin
                valid_q <= valid_d;
                if (valid_d) begin
                    tag_q  <= tag_d;
                    prod_q <= prod_d;
`ifdef KUL_MULT_ERR_FLAG_EN
                    err_q  <= err_d;
`endif
                end
            end
        end
    end

    assign out_valid = g_stage[L].valid_q;
    assign out_y     = g_stage[L].prod_q[0];
    assign out_tag   = g_stage[L].tag_q;
`ifdef KUL_MULT_ERR_FLAG_EN
    assign out_err   = g_stage[L].err_q;
`endif

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

endmodule

// File: tb/tb_kul_mult_pipe.sv
// Self-checking bench for kul_mult_pipe (WIDTH=8, TAG_W=4), directed vectors plus a digit model.
module tb_kul_mult_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned TAG_W = 4;
    localparam int LAT = 3;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              in_approx;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [2*WIDTH-1:0] out_y;
    logic [TAG_W-1:0]  out_tag;
`ifdef KUL_MULT_ERR_FLAG_EN
    logic              out_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];

    kul_mult_pipe #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_approx (in_approx),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
`ifdef KUL_MULT_ERR_FLAG_EN
        .out_err   (out_err),
`endif
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sum of 2x2 digit products, each 3x3 replaced by 7 in approximate mode
    function automatic logic [15:0] model_y(input logic [7:0] a, input logic [7:0] b,
                                            input logic ap);
        logic [15:0] y;
        logic [1:0]  da, db;
        logic [3:0]  p;
        y = '0;
        for (int ii = 0; ii < 4; ii++) begin
            for (int jj = 0; jj < 4; jj++) begin
                da = a[2*ii +: 2];
                db = b[2*jj +: 2];
                p  = {2'b00, da} * {2'b00, db};
                if (ap && da == 2'd3 && db == 2'd3) p = 4'd7;
                y = y + (16'(p) << (2 * (ii + jj)));
            end
        end
        return y;
    endfunction

    function automatic logic model_err(input logic [7:0] a, input logic [7:0] b, input logic ap);
        return ap && (model_y(a, b, 1'b1) != 16'(a) * 16'(b));
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic ap,
                           input logic [3:0] tag, output logic [15:0] y, output logic [3:0] t,
                           output logic e, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_approx = ap;
        in_tag    = tag;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        y = out_y;
        t = out_tag;
`ifdef KUL_MULT_ERR_FLAG_EN
        e = out_err;
`else
        e = 1'b0;
`endif
        step();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_y !== 16'h0000) begin
            errors++; $display("FAIL reset_y: got %h expected 0000", out_y);
        end
        checks++;
        if (out_tag !== 4'h0) begin
            errors++; $display("FAIL reset_tag: got %h expected 0", out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
`ifdef KUL_MULT_ERR_FLAG_EN
        checks++;
        if (out_err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", out_err);
        end
`endif
    endtask

    task automatic test_exact_ones;
        logic [15:0] y; logic [3:0] t; logic e; int lat;
        run_one(8'hFF, 8'hFF, 1'b0, 4'd5, y, t, e, lat);
        checks++;
        if (lat !== LAT) begin
            errors++; $display("FAIL exact_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (y !== 16'hFE01) begin
            errors++; $display("FAIL exact_ones_y: got %h expected fe01", y);
        end
        checks++;
        if (t !== 4'd5) begin
            errors++; $display("FAIL exact_ones_tag: got %0d expected 5", t);
        end
`ifdef KUL_MULT_ERR_FLAG_EN
        checks++;
        if (e !== 1'b0) begin
            errors++; $display("FAIL exact_ones_err: got %b expected 0", e);
        end
`endif
    endtask

    task automatic test_approx_ones;
        logic [15:0] y; logic [3:0] t; logic e; int lat;
        run_one(8'hFF, 8'hFF, 1'b1, 4'd9, y, t, e, lat);
        checks++;
        if (y !== 16'hC58F) begin
            errors++; $display("FAIL approx_ones_y: got %h expected c58f", y);
        end
        checks++;
        if (t !== 4'd9) begin
            errors++; $display("FAIL approx_ones_tag: got %0d expected 9", t);
        end
`ifdef KUL_MULT_ERR_FLAG_EN
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL approx_ones_err: got %b expected 1", e);
        end
`endif
    endtask

    task automatic test_small;
        logic [15:0] y; logic [3:0] t; logic e; int lat;
        run_one(8'h02, 8'h03, 1'b1, 4'd3, y, t, e, lat);
        checks++;
        if (y !== 16'h0006) begin
            errors++; $display("FAIL small_2x3_y: got %h expected 0006", y);
        end
`ifdef KUL_MULT_ERR_FLAG_EN
        checks++;
        if (e !== 1'b0) begin
            errors++; $display("FAIL small_2x3_err: got %b expected 0", e);
        end
`endif
        run_one(8'h03, 8'h03, 1'b1, 4'd12, y, t, e, lat);
        checks++;
        if (y !== 16'h0007) begin
            errors++; $display("FAIL small_3x3_y: got %h expected 0007", y);
        end
        checks++;
        if (t !== 4'd12) begin
            errors++; $display("FAIL small_3x3_tag: got %0d expected 12", t);
        end
`ifdef KUL_MULT_ERR_FLAG_EN
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL small_3x3_err: got %b expected 1", e);
        end
`endif
    endtask

    task automatic test_back_to_back;
        exp_t ex, f;
        int got = 0, first = -1, last = -1, not_ready = 0;
        q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc < 20) begin
                in_valid  = 1'b1;
                in_a      = 8'($urandom_range(0, 255));
                in_b      = 8'($urandom_range(0, 255));
                in_approx = cyc[0];
                in_tag    = 4'(cyc);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && !in_ready) not_ready++;
            if (in_valid && in_ready) begin
                ex.y   = model_y(in_a, in_b, in_approx);
                ex.tag = in_tag;
                ex.err = model_err(in_a, in_b, in_approx);
                q.push_back(ex);
            end
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                got++;
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra: got result %h with none pending", out_y);
                end else begin
                    f = q.pop_front();
                    if (out_y !== f.y || out_tag !== f.tag) begin
                        errors++;
                        $display("FAIL stream_data: got y=%h tag=%0d expected y=%h tag=%0d",
                                 out_y, out_tag, f.y, f.tag);
                    end
`ifdef KUL_MULT_ERR_FLAG_EN
                    checks++;
                    if (out_err !== f.err) begin
                        errors++; $display("FAIL stream_err: got %b expected %b", out_err, f.err);
                    end
`endif
                end
            end
            step();
        end
        checks++;
        if (not_ready !== 0) begin
            errors++; $display("FAIL stream_in_ready: got %0d stalled cycles expected 0", not_ready);
        end
        checks++;
        if (got !== 20) begin
            errors++; $display("FAIL stream_count: got %0d expected 20", got);
        end
        checks++;
        if (first !== LAT || last !== LAT + 19) begin
            errors++;
            $display("FAIL stream_timing: got first=%0d last=%0d expected first=%0d last=%0d",
                     first, last, LAT, LAT + 19);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] va[4];
        logic [7:0] vb[4];
        logic [15:0] hy;
        logic [3:0]  ht;
        exp_t ex, f;
        int issued = 0, got = 0, hold = 0;
        va = '{8'h12, 8'hF3, 8'h7C, 8'hFF};
        vb = '{8'h34, 8'hBF, 8'hE7, 8'h0F};
        hy = '0;
        ht = '0;
        q.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (issued < 4) begin
                in_valid  = 1'b1;
                in_a      = va[issued];
                in_b      = vb[issued];
                in_approx = issued[0];
                in_tag    = 4'(8 + issued);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (hold >= 5);
            #1;
            if (out_valid && !out_ready) begin
                hold++;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready);
                end
                if (hold == 1) begin
                    hy = out_y;
                    ht = out_tag;
                end else begin
                    checks++;
                    if (out_y !== hy || out_tag !== ht) begin
                        errors++;
                        $display("FAIL bp_stable: got y=%h tag=%0d expected y=%h tag=%0d",
                                 out_y, out_tag, hy, ht);
                    end
                end
            end
            if (in_valid && in_ready) begin
                ex.y   = model_y(in_a, in_b, in_approx);
                ex.tag = in_tag;
                ex.err = model_err(in_a, in_b, in_approx);
                q.push_back(ex);
                issued++;
            end
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_dup: got extra result %h expected none", out_y);
                end else begin
                    f = q.pop_front();
                    if (out_y !== f.y || out_tag !== f.tag) begin
                        errors++;
                        $display("FAIL bp_data: got y=%h tag=%0d expected y=%h tag=%0d",
                                 out_y, out_tag, f.y, f.tag);
                    end
                end
            end
            step();
        end
        out_ready = 1'b1;
        checks++;
        if (hold !== 5) begin
            errors++; $display("FAIL bp_hold: got %0d stalled cycles expected 5", hold);
        end
        checks++;
        if (got !== 4 || q.size() !== 0) begin
            errors++; $display("FAIL bp_count: got %0d results, %0d pending expected 4, 0",
                               got, q.size());
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_approx = 1'b0;
        in_a      = 8'hFF;
        in_b      = 8'hFF;
        in_tag    = 4'd1;
        step();
        in_a   = 8'h03;
        in_b   = 8'h03;
        in_tag = 4'd2;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_y !== 16'h0000 || out_tag !== 4'h0) begin
            errors++; $display("FAIL rstmid_y: got y=%h tag=%0d expected 0000 0", out_y, out_tag);
        end
        rst = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rstmid_ghost: got %0d results expected 0", seen);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_approx = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        test_reset();
        test_exact_ones();
        test_approx_ones();
        test_small();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
